// File: rtl/usb_tx_ctrl.sv
// Full-speed USB packet transmitter: SYNC, PID and FIFO data bytes sent LSB first
// with bit stuffing and NRZI onto D+/D-, closed by an SE0-SE0-J end of packet.
module usb_tx_ctrl #(
  parameter int CLKS_PER_BIT = 8,
  parameter int MAX_LEN      = 64,
  localparam int LW          = $clog2(MAX_LEN + 1),
  localparam int TW          = $clog2(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tx_start,
  input  logic [3:0]    tx_pid,
  input  logic [LW-1:0] tx_len,
  input  logic [7:0]    fifo_rdata,
  input  logic          fifo_empty,
  output logic          fifo_rd,
  output logic          d_plus,
  output logic          d_minus,
  output logic          tx_busy,
  output logic          tx_done,
  output logic          tx_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SYNC    = 3'd1;
  localparam logic [2:0] S_PID     = 3'd2;
  localparam logic [2:0] S_DATA    = 3'd3;
  localparam logic [2:0] S_EOP_SE0 = 3'd4;
  localparam logic [2:0] S_EOP_J   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    sr_q, sr_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [2:0]    ones_q, ones_d;
  logic          level_q, level_d;
  logic          se0_q, se0_d;
  logic [3:0]    pid_q, pid_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          err_q, err_d;

  logic          bit_end;
  logic          send_bit;
  logic          bit_val;

  assign bit_end = (timer_q == TW'(CLKS_PER_BIT - 1));

  always_comb begin
    // NOTE: every signal gets a default here so no path through the case infers a latch.
    state_d   = state_q;
    timer_d   = timer_q;
    sr_d      = sr_q;
    bit_idx_d = bit_idx_q;
    ones_d    = ones_q;
    level_d   = level_q;
    se0_d     = se0_q;
    pid_d     = pid_q;
    rem_d     = rem_q;
    err_d     = err_q;
    fifo_rd   = 1'b0;
    tx_done   = 1'b0;
    send_bit  = 1'b0;
    bit_val   = 1'b0;

    if (state_q != S_IDLE) timer_d = bit_end ? '0 : timer_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          state_d   = S_SYNC;
          timer_d   = '0;
          pid_d     = tx_pid;
          rem_d     = tx_len;
          err_d     = 1'b0;
          sr_d      = 8'h80;
          bit_idx_d = 3'd0;
          send_bit  = 1'b1;
          bit_val   = 1'b0;
        end
      end

      // The byte-load decision takes no bit time, so it lives on the last
      // boundary of the preceding byte rather than in a state of its own.
      S_SYNC, S_PID, S_DATA: begin
        if (bit_end) begin
          if (ones_q == 3'd6) begin
            send_bit = 1'b1;
            bit_val  = 1'b0;
          end else if (bit_idx_q != 3'd7) begin
            sr_d      = {1'b0, sr_q[7:1]};
            bit_idx_d = bit_idx_q + 1'b1;
            send_bit  = 1'b1;
            bit_val   = sr_q[1];
          end else if (state_q == S_SYNC) begin
            state_d   = S_PID;
            sr_d      = {~pid_q, pid_q};
            bit_idx_d = 3'd0;
            send_bit  = 1'b1;
            bit_val   = pid_q[0];
          end else if (rem_q == '0) begin
            state_d   = S_EOP_SE0;
            se0_d     = 1'b1;
            bit_idx_d = 3'd0;
          end else if (fifo_empty) begin
            err_d     = 1'b1;
            state_d   = S_EOP_SE0;
            se0_d     = 1'b1;
            bit_idx_d = 3'd0;
          end else begin
            fifo_rd   = 1'b1;
            rem_d     = rem_q - 1'b1;
            state_d   = S_DATA;
            sr_d      = fifo_rdata;
            bit_idx_d = 3'd0;
            send_bit  = 1'b1;
            bit_val   = fifo_rdata[0];
          end
        end
      end

      S_EOP_SE0: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd0) begin
            bit_idx_d = 3'd1;
          end else begin
            state_d = S_EOP_J;
            se0_d   = 1'b0;
            level_d = 1'b1;
          end
        end
      end

      S_EOP_J: begin
        if (bit_end) begin
          tx_done = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // NRZI plus ones counting; stuffed zeros flow through here like any other 0.
    if (send_bit) begin
      if (bit_val) begin
        ones_d = ones_q + 3'd1;
      end else begin
        ones_d  = 3'd0;
        level_d = ~level_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      sr_q      <= '0;
      bit_idx_q <= '0;
      ones_q    <= '0;
      level_q   <= 1'b1;
      se0_q     <= 1'b0;
      pid_q     <= '0;
      rem_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sr_q      <= sr_d;
      bit_idx_q <= bit_idx_d;
      ones_q    <= ones_d;
      level_q   <= level_d;
      se0_q     <= se0_d;
      pid_q     <= pid_d;
      rem_q     <= rem_d;
      err_q     <= err_d;
    end
  end

  assign d_plus  = ~se0_q & level_q;
  assign d_minus = ~se0_q & ~level_q;
  assign tx_busy = (state_q != S_IDLE);
  assign tx_err  = err_q;

endmodule
